// File: rtl/uart_tx_record.sv
// uart_tx_record: serialises {addr, count} histogram records as UART frames, MSB byte first
module uart_tx_record #(
  parameter int WIDTH_DATA  = 16,
  parameter int LENGTH_ADDR = 10,
  parameter int BAUD_DIV    = 10417,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rec_valid,
  output logic                   rec_ready,
  input  logic [WIDTH_DATA-1:0]  rec_data,
  output logic [LENGTH_ADDR-1:0] addr,
  output logic                   addr_wrap,
  output logic                   busy,
  output logic                   txd
);
  localparam int ND = (WIDTH_DATA + 7) / 8;
  localparam int NA = (LENGTH_ADDR + 7) / 8;
  localparam int NB = NA + ND;
  localparam int SW = 8 * NB;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(NB) + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  localparam bit HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit ODD = PARITY_MODE == 2;
  localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  logic [2:0]    state, bit_cnt, bit_nx;
  logic [BW-1:0] baud_cnt;
  logic [CW-1:0] byte_cnt;
  logic [SW-1:0] shreg;
  logic [7:0]    cur;
  logic          tick;
  assign cur       = shreg[SW-1 -: 8];
  assign bit_nx    = bit_cnt + 3'd1;
  assign tick      = baud_cnt == BAUD_MAX;
  assign rec_ready = (state == IDLE) && !rst;
  assign busy      = state != IDLE;
  // txd is loaded with the level of the state being entered, so each bit lasts exactly BAUD_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      txd       <= 1'b1;
      addr      <= '0;
      addr_wrap <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
    end else begin
      addr_wrap <= 1'b0;
      if (state == IDLE) begin
        if (rec_valid) begin
          shreg    <= {(8*NA)'(addr), (8*ND)'(rec_data)};
          byte_cnt <= CW'(NB - 1);
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= START;
          txd      <= 1'b0;
        end
      end else if (!tick) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            txd     <= cur[0];
          end
          DATA:
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_nx;
              txd     <= cur[bit_nx];
            end else if (HAS_PAR) begin
              state <= PARITY;
              txd   <= ^cur ^ ODD;
            end else begin
              state   <= STOP;
              bit_cnt <= '0;
              txd     <= 1'b1;
            end
          PARITY: begin
            state   <= STOP;
            bit_cnt <= '0;
            txd     <= 1'b1;
          end
          default:
            if (bit_cnt != LAST_STOP) begin
              bit_cnt <= bit_nx;
            end else if (byte_cnt != '0) begin
              byte_cnt <= byte_cnt - 1'b1;
              shreg    <= shreg << 8;
              state    <= START;
              txd      <= 1'b0;
            end else begin
              state     <= IDLE;
              addr      <= addr + 1'b1;
              addr_wrap <= &addr;
              txd       <= 1'b1;
            end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_record.sv
// tb_uart_tx_record: random records checked cycle by cycle against an arithmetic line model
module tb_uart_tx_record;
  logic clk = 1'b0, rst = 1'b1, v = 1'b0, dv = 1'b0;
  logic [15:0] rd = '0;
  logic [7:0]  drd = '0;
  logic a_ready, a_wrap, a_busy, a_txd, b_ready, b_wrap, b_busy, b_txd;
  logic c_ready, c_wrap, c_busy, c_txd, d_ready, d_wrap, d_busy, d_txd;
  logic [9:0] a_addr, b_addr, c_addr;
  logic [8:0] d_addr;
  int checks = 0, failures = 0, wrap_cnt = 0, exp_addr = 0;

  uart_tx_record #(.BAUD_DIV(4), .PARITY_MODE(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rec_valid(v), .rec_ready(a_ready), .rec_data(rd),
    .addr(a_addr), .addr_wrap(a_wrap), .busy(a_busy), .txd(a_txd));
  uart_tx_record #(.BAUD_DIV(4), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .rec_valid(v), .rec_ready(b_ready), .rec_data(rd),
    .addr(b_addr), .addr_wrap(b_wrap), .busy(b_busy), .txd(b_txd));
  uart_tx_record #(.BAUD_DIV(4), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .rec_valid(v), .rec_ready(c_ready), .rec_data(rd),
    .addr(c_addr), .addr_wrap(c_wrap), .busy(c_busy), .txd(c_txd));
  uart_tx_record #(.WIDTH_DATA(8), .LENGTH_ADDR(9), .BAUD_DIV(2), .PARITY_MODE(3), .STOP_BITS(1)) dut_d (
    .clk(clk), .rst(rst), .rec_valid(dv), .rec_ready(d_ready), .rec_data(drd),
    .addr(d_addr), .addr_wrap(d_wrap), .busy(d_busy), .txd(d_txd));

  always #5 clk = ~clk;
  always @(posedge clk) if (d_wrap) wrap_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected line level k cycles after the handshake edge
  function automatic logic exp_bit(int k, int baud, int pm, int sb, int na, int nd,
                                   logic [63:0] a, logic [63:0] d);
    int par = (pm == 1 || pm == 2) ? 1 : 0;
    int fb = 10 + par + ((sb == 2) ? 1 : 0);
    int nb = na + nd;
    int bp = k / baud;
    int by = bp / fb;
    int b = bp % fb;
    logic [63:0] r = (a << (8 * nd)) | d;
    logic [7:0] byt;
    if (by >= nb) return 1'b1;
    byt = 8'(r >> (8 * (nb - 1 - by)));
    if (b == 0) return 1'b0;
    if (b <= 8) return byt[b-1];
    if (b == 9 && par == 1) return ^byt ^ (pm == 2);
    return 1'b1;
  endfunction

  // caller leaves v=1 and rd=d so the next posedge is the handshake
  task automatic record_abc(input logic [15:0] d, input logic [15:0] dnext, input bit hold);
    int ma = 0, mb = 0, mc = 0, mz = 0;
    @(posedge clk);
    #1 rd = dnext;
    if (!hold) v = 1'b0;
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (a_txd !== exp_bit(k, 4, 1, 1, 2, 2, 64'(exp_addr), 64'(d))) ma++;
      if (b_txd !== exp_bit(k, 4, 2, 1, 2, 2, 64'(exp_addr), 64'(d))) mb++;
      if (c_txd !== exp_bit(k, 4, 0, 2, 2, 2, 64'(exp_addr), 64'(d))) mc++;
      if (!(a_busy && b_busy && c_busy) || a_ready || b_ready || c_ready) mz++;
    end
    check("wave_even", 64'(ma), 0);
    check("wave_odd", 64'(mb), 0);
    check("wave_nopar_2stop", 64'(mc), 0);
    check("busy_during_record", 64'(mz), 0);
    exp_addr = (exp_addr + 1) % 1024;
    @(negedge clk);
    check("idle_txd", {a_txd, b_txd, c_txd}, 3'b111);
    check("idle_ready", {a_ready, b_ready, c_ready}, 3'b111);
    check("addr_a", 64'(a_addr), 64'(exp_addr));
    check("addr_c", 64'(c_addr), 64'(exp_addr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d0, d1, d2, x;
    int md;
    repeat (3) @(negedge clk);
    check("rst_txd", {a_txd, d_txd}, 2'b11);
    check("rst_addr", 64'(a_addr), 0);
    check("rst_ready", {a_ready, d_ready}, 2'b00);
    check("rst_busy", {a_busy, d_busy}, 2'b00);
    check("rst_wrap", {a_wrap, d_wrap}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {a_ready, b_ready, c_ready, d_ready}, 4'b1111);
    v = 1'b1; rd = 16'hA55A;
    record_abc(16'hA55A, 16'(urand16()), 1'b0);
    repeat (2) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      x = 16'($urandom);
      v = 1'b1; rd = x;
      record_abc(x, 16'($urandom), 1'b0);
    end
    d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
    v = 1'b1; rd = d0;
    record_abc(d0, d1, 1'b1);
    record_abc(d1, d2, 1'b1);
    record_abc(d2, 16'($urandom), 1'b0);
    check("addr_before_abort", 64'(a_addr), 6);
    v = 1'b1; rd = 16'($urandom);
    @(posedge clk);
    #1 v = 1'b0;
    repeat (97) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_txd", {a_txd, b_txd, c_txd}, 3'b111);
    check("abort_addr", 64'(a_addr), 0);
    check("abort_busy", {a_busy, b_busy, c_busy}, 3'b000);
    check("abort_ready_in_rst", 64'(a_ready), 0);
    rst = 1'b0;
    exp_addr = 0;
    @(negedge clk);
    check("ready_after_abort", 64'(a_ready), 1);
    x = 16'($urandom);
    v = 1'b1; rd = x;
    record_abc(x, 16'($urandom), 1'b0);
    dv = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (d_addr == 9'h1ff && d_ready) break;
      drd = 8'($urandom);
    end
    check("preload_addr", 64'(d_addr), 64'h1ff);
    check("no_early_wrap", 64'(wrap_cnt), 0);
    drd = 8'h3C;
    @(posedge clk);
    #1 dv = 1'b0;
    drd = 8'($urandom);
    md = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_txd !== exp_bit(k, 2, 3, 1, 2, 1, 64'h1ff, 64'h3C)) md++;
    end
    check("wave_wrap_record", 64'(md), 0);
    @(negedge clk);
    check("wrap_addr", 64'(d_addr), 0);
    check("wrap_pulse", 64'(d_wrap), 1);
    check("wrap_idle_txd", 64'(d_txd), 1);
    @(negedge clk);
    check("wrap_pulse_end", 64'(d_wrap), 0);
    check("wrap_count", 64'(wrap_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic int urand16();
    return int'($urandom_range(0, 65535));
  endfunction
endmodule

// File: doc/uart_tx_record.md
Name: uart_tx_record

Overview:
- Parametrised UART record transmitter for the code-density readout path.
- Accepts one histogram record (bin address + count word) per valid/ready handshake and serialises it as a sequence of UART frames, MSB byte first.
- Internal baud divider, configurable parity mode and stop-bit count, and an auto-incrementing bin address that drives the histogram RAM read port.

Parameters:
- WIDTH_DATA, 16, count word width; data bytes ND = ceil(WIDTH_DATA/8).
- LENGTH_ADDR, 10, bin address width; address bytes NA = ceil(LENGTH_ADDR/8).
- BAUD_DIV, 10417, clk cycles per UART bit (100 MHz / 9600); must be >= 2.
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset, synchronous, active-high.
- rec_valid, input, 1, record available (e.g. FIFO not-empty).
- rec_ready, output, 1, block can accept a record.
- rec_data, input, WIDTH_DATA, count word for the current addr.
- addr, output, LENGTH_ADDR, current bin address (histogram RAM read address).
- addr_wrap, output, 1, one-cycle pulse when addr wraps to 0.
- busy, output, 1, transmission in progress.
- txd, output, 1, registered serial line.

Behaviour:
- Reset values: txd=1, addr=0, rec_ready=0 during rst, busy=0, addr_wrap=0; FSM to IDLE; baud and bit counters cleared.
- Reset mid-frame aborts immediately: txd=1 on the cycle after rst is sampled; the partial record is discarded.
- Record shift register width 8*(NA+ND) = {zero-padded addr, zero-padded rec_data}.
  - Byte order: address bytes MSB first, then data bytes MSB first.
  - Bits within a byte are sent LSB first.
- rec_ready = 1 only in IDLE and not in rst.
- Handshake (rec_valid & rec_ready) captures rec_data and the current addr into the shift register, loads the byte counter with NA+ND-1, clears the baud counter, and enters START.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake.
  - START -> DATA after one bit period.
  - DATA -> PARITY after 8 bit periods when PARITY_MODE != 0; otherwise DATA -> STOP.
  - STOP -> START (next byte) after STOP_BITS periods when the byte counter > 0; otherwise STOP -> IDLE.
- Bit timing:
  - txd is registered and takes each state's level on the first clk after the state is entered.
  - Every bit is held exactly BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1; the tick is at BAUD_DIV-1 and the counter restarts.
  - txd drops to 0 on the cycle after the handshake.
- Line levels: start bit 0; stop bits 1.
- Parity:
  - Even mode: parity bit = XOR of the 8 data bits.
  - Odd mode: parity bit = inverted XOR of the 8 data bits.
- Frame length: 1 + 8 + (PARITY_MODE != 0) + STOP_BITS bits. A record lasts (NA+ND) * frame_bits * BAUD_DIV cycles with no gap between bytes.
- End of record: on the final stop-bit tick, addr increments modulo 2^LENGTH_ADDR, the FSM enters IDLE, and rec_ready rises on the next cycle.
  - Minimum inter-record idle time is 1 cycle (txd=1).
- addr_wrap pulses for one cycle on the cycle addr goes from 2^LENGTH_ADDR-1 to 0.
- busy = 1 in every state except IDLE.
- rec_data and rec_valid are don't-care outside the handshake cycle; later changes of rec_data do not alter the frame in flight.
- Illegal PARITY_MODE (3) behaves as none. STOP_BITS other than 2 behaves as 1.

Test Plan:
- BAUD_DIV=4, PARITY_MODE=1, STOP_BITS=1, addr=0, rec_data=16'hA55A, single valid pulse -> bytes 00,00,A5,5A.
  - Each frame is 11 bits x 4 cycles; A5 frame bits = 0,1,0,1,0,0,1,0,1,0,1 (parity 0).
  - Record lasts 176 cycles; then addr=1 and rec_ready=1.
- Same stimulus with PARITY_MODE=2 -> every parity bit inverted (A5 frame parity = 1); frame timing unchanged.
- PARITY_MODE=0, STOP_BITS=2 -> each frame 11 bits (start, 8 data, 2 stop); no parity slot; record lasts 176 cycles.
- rec_valid held high for 3 records, rec_data changing after each handshake -> addr sequence 0,1,2; exactly 1 idle cycle between records; each record carries its own captured rec_data.
- Preload addr to 1023 by sending 1023 records (BAUD_DIV=2), then send one more -> its address bytes are 03,FF; addr goes to 0 and addr_wrap pulses for exactly 1 cycle.
- rst asserted mid-data bit of byte 2 -> next cycle txd=1, addr=0, busy=0; rec_ready=1 after rst deasserts; the next record starts cleanly with a start bit.
